eth_dma_wr_burst: RTL

- Upstream stage of the Ethernet core DMA export path: drives the `s_dma_avl_*` write side of the DMA slave port.
- Accepts a received frame as a 64-bit valid/ready stream and buffers it in an internal FIFO.
- Writes the frame to memory as Avalon-MM write bursts, starting at a programmed base address.
- Reports completion with a one-cycle done pulse and the frame word count.

---
 rtl/eth_dma_wr_burst.sv | 196 +++++++++++++++++++
 1 files changed

// File: rtl/eth_dma_wr_burst.sv
// Ethernet DMA write-burst engine: buffers a received 64-bit frame stream in a FIFO
// and writes it to memory as Avalon-MM bursts starting at a programmed base address.
//
// state | meaning
// IDLE  | waiting for cfg_start
// FILL  | accepting stream words, deciding when the next burst can go
// BURST | issuing beats of one burst from the FIFO head
// DONE  | one-cycle completion: done_pulse, done_words captured
module eth_dma_wr_burst #(
  parameter int pDATA_WIDTH = 64,
  parameter int pADDR_WIDTH = 32,
  parameter int pBURST_MAX  = 16,
  parameter int pFIFO_DEPTH = 64
) (
  input  logic                   avl_clock,
  input  logic                   avl_rst,
  input  logic [pADDR_WIDTH-1:0] cfg_base_addr,
  input  logic                   cfg_start,
  output logic                   busy,
  output logic                   done_pulse,
  output logic [15:0]            done_words,
  input  logic                   s_st_valid,
  output logic                   s_st_ready,
  input  logic [pDATA_WIDTH-1:0] s_st_data,
  input  logic                   s_st_last,
  output logic [pADDR_WIDTH-1:0] m_dma_avl_addr,
  output logic                   m_dma_avl_wrena,
  output logic [pDATA_WIDTH-1:0] m_dma_avl_wrdata,
  output logic [7:0]             m_dma_avl_burst_cnt,
  input  logic                   m_dma_avl_wrq
);

  localparam int PTR_W = $clog2(pFIFO_DEPTH);
  localparam int LVL_W = PTR_W + 1;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_FILL  = 2'd1;
  localparam logic [1:0] ST_BURST = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  localparam logic [LVL_W-1:0] LVL_FULL  = LVL_W'(pFIFO_DEPTH);
  localparam logic [LVL_W-1:0] LVL_BURST = LVL_W'(pBURST_MAX);
  localparam logic [LVL_W-1:0] LVL_ZERO  = '0;
  localparam logic [7:0]       CNT_BURST = 8'(pBURST_MAX);

  logic [1:0]             state_q, state_d;
  logic [pADDR_WIDTH-1:0] cur_addr_q, cur_addr_d;
  logic [15:0]            word_cnt_q, word_cnt_d;
  logic                   eop_q, eop_d;
  logic                   busy_q, busy_d;
  logic                   done_pulse_q, done_pulse_d;
  logic [15:0]            done_words_q, done_words_d;
  logic [7:0]             burst_cnt_q, burst_cnt_d;
  logic [7:0]             beat_cnt_q, beat_cnt_d;
  logic                   wrena_q, wrena_d;
  logic [PTR_W-1:0]       wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]       rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0]       level_q, level_d;
  logic [pDATA_WIDTH-1:0] fifo_mem_q [pFIFO_DEPTH];

  logic push;
  logic pop;
  logic unused_base_bits;

  // The low address bits are forced to zero: bursts are always word aligned.
  assign unused_base_bits = ^cfg_base_addr[2:0];

  assign s_st_ready = ((state_q == ST_FILL) || (state_q == ST_BURST)) && !eop_q
                      && (level_q < LVL_FULL);
  assign push = s_st_valid && s_st_ready;
  assign pop  = (state_q == ST_BURST) && wrena_q && !m_dma_avl_wrq;

  always_comb begin
    state_d      = state_q;
    cur_addr_d   = cur_addr_q;
    word_cnt_d   = word_cnt_q;
    eop_d        = eop_q;
    busy_d       = busy_q;
    done_pulse_d = 1'b0;
    done_words_d = done_words_q;
    burst_cnt_d  = burst_cnt_q;
    beat_cnt_d   = beat_cnt_q;
    wrena_d      = wrena_q;
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    level_d      = level_q + {{(LVL_W-1){1'b0}}, push} - {{(LVL_W-1){1'b0}}, pop};

    if (push) begin
      wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (word_cnt_q != 16'hFFFF) begin
        word_cnt_d = word_cnt_q + 16'd1;
      end
      if (s_st_last) begin
        eop_d = 1'b1;
      end
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end

    case (state_q)
      ST_IDLE: begin
        if (cfg_start) begin
          cur_addr_d = {cfg_base_addr[pADDR_WIDTH-1:3], 3'b000};
          word_cnt_d = 16'd0;
          eop_d      = 1'b0;
          busy_d     = 1'b1;
          state_d    = ST_FILL;
        end
      end
      ST_FILL: begin
        if (level_q >= LVL_BURST) begin
          burst_cnt_d = CNT_BURST;
          beat_cnt_d  = 8'd0;
          wrena_d     = 1'b1;
          state_d     = ST_BURST;
        end else if (eop_q && (level_q != LVL_ZERO)) begin
          // Tail of the frame: level is below the burst size here, so it fits 8 bits.
          burst_cnt_d = 8'(level_q);
          beat_cnt_d  = 8'd0;
          wrena_d     = 1'b1;
          state_d     = ST_BURST;
        end else if (eop_q) begin
          done_pulse_d = 1'b1;
          done_words_d = word_cnt_q;
          busy_d       = 1'b0;
          state_d      = ST_DONE;
        end
      end
      ST_BURST: begin
        if (pop) begin
          beat_cnt_d = beat_cnt_q + 8'd1;
          if (beat_cnt_q == (burst_cnt_q - 8'd1)) begin
            wrena_d    = 1'b0;
            cur_addr_d = cur_addr_q + pADDR_WIDTH'({burst_cnt_q, 3'b000});
            state_d    = ST_FILL;
          end
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge avl_clock or posedge avl_rst) begin
    if (avl_rst) begin
      state_q      <= ST_IDLE;
      cur_addr_q   <= '0;
      word_cnt_q   <= '0;
      eop_q        <= 1'b0;
      busy_q       <= 1'b0;
      done_pulse_q <= 1'b0;
      done_words_q <= '0;
      burst_cnt_q  <= '0;
      beat_cnt_q   <= '0;
      wrena_q      <= 1'b0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      level_q      <= '0;
    end else begin
      state_q      <= state_d;
      cur_addr_q   <= cur_addr_d;
      word_cnt_q   <= word_cnt_d;
      eop_q        <= eop_d;
      busy_q       <= busy_d;
      done_pulse_q <= done_pulse_d;
      done_words_q <= done_words_d;
      burst_cnt_q  <= burst_cnt_d;
      beat_cnt_q   <= beat_cnt_d;
      wrena_q      <= wrena_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      level_q      <= level_d;
    end
  end

  // Storage needs no reset; the pointers and level define what is valid.
  always_ff @(posedge avl_clock) begin
    if (push) begin
      fifo_mem_q[wr_ptr_q] <= s_st_data;
    end
  end

  assign busy                = busy_q;
  assign done_pulse          = done_pulse_q;
  assign done_words          = done_words_q;
  assign m_dma_avl_addr      = cur_addr_q;
  assign m_dma_avl_wrena     = wrena_q;
  assign m_dma_avl_burst_cnt = burst_cnt_q;
  assign m_dma_avl_wrdata    = wrena_q ? fifo_mem_q[rd_ptr_q] : '0;

endmodule
